// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int DEFAULT_WORD_SIZE  = 16;
    localparam int DEFAULT_STARVE_MAX = 4;
    localparam int DEFAULT_CNT_W      = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_perf_cnt.sv
// Wait-cycle and grant counters for the memory arbiter; free-running, wrap on overflow.
module mem_arb_perf_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_stall,
    input  logic             d_stall,
    input  logic             grant,
    output logic [CNT_W-1:0] perf_i_wait,
    output logic [CNT_W-1:0] perf_d_wait,
    output logic [CNT_W-1:0] perf_grants
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_i_wait <= '0;
            perf_d_wait <= '0;
            perf_grants <= '0;
        end else begin
            if (i_stall) perf_i_wait <= perf_i_wait + 1'b1;
            if (d_stall) perf_d_wait <= perf_d_wait + 1'b1;
            if (grant)   perf_grants <= perf_grants + 1'b1;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data (LD/SWD) ports.
// Optional performance counters are built when ARB_PERF_CNT_EN is defined.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int  WORD_SIZE  = DEFAULT_WORD_SIZE,
    parameter int  STARVE_MAX = DEFAULT_STARVE_MAX,
    parameter int  CNT_W      = DEFAULT_CNT_W,
    localparam int SW         = $clog2(STARVE_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_done,
    output logic                 i_stall,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_done,
    output logic                 d_stall,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ack,
    output logic                 busy,
`ifdef ARB_PERF_CNT_EN
    output logic [CNT_W-1:0]     perf_i_wait,
    output logic [CNT_W-1:0]     perf_d_wait,
    output logic [CNT_W-1:0]     perf_grants,
`endif
    output state_t               state_dbg,
    output logic [SW-1:0]        starve_dbg
);

    // Handshake: a requester raises req (level) with stable addr/we/wdata and
    // holds it until its one-cycle done pulse; the memory side sees mem_req
    // held with stable we/addr/wdata until it answers with a one-cycle mem_ack.

    state_t        state, state_nxt;
    owner_t        owner;
    logic [SW-1:0] starve_cnt;
    logic          grant, grant_d;

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    grant     = 1'b1;
                    // D belongs to the older instruction, unless fetch has waited too long
                    grant_d   = d_req && !(i_req && starve_cnt == SW'(STARVE_MAX));
                    state_nxt = BUSY;
                end
            end
            BUSY:    if (mem_ack) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWN_I;
            starve_cnt <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner     <= grant_d ? OWN_D : OWN_I;
                mem_we    <= grant_d & d_we;
                mem_addr  <= grant_d ? d_addr : i_addr;
                mem_wdata <= grant_d ? d_wdata : '0;
                if (grant_d && i_req) begin
                    if (starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
                end else begin
                    starve_cnt <= '0;
                end
            end
            if (state == BUSY && mem_ack && !mem_we) begin
                if (owner == OWN_I) i_rdata <= mem_rdata;
                else                d_rdata <= mem_rdata;
            end
        end
    end

    assign mem_req    = (state == BUSY);
    assign busy       = (state != IDLE);
    assign i_done     = (state == RESP) && (owner == OWN_I);
    assign d_done     = (state == RESP) && (owner == OWN_D);
    assign i_stall    = i_req & ~i_done;
    assign d_stall    = d_req & ~d_done;
    assign state_dbg  = state;
    assign starve_dbg = starve_cnt;

`ifdef ARB_PERF_CNT_EN
    mem_arb_perf_cnt #(.CNT_W(CNT_W)) u_perf (
        .clk         (clk),
        .reset       (reset),
        .i_stall     (i_stall),
        .d_stall     (d_stall),
        .grant       (grant),
        .perf_i_wait (perf_i_wait),
        .perf_d_wait (perf_d_wait),
        .perf_grants (perf_grants)
    );
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios plus random traffic against a timestamp model.
module tb_unified_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int W          = 16;
    localparam int STARVE_MAX = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic         i_req, d_req, d_we, mem_ack;
    logic [W-1:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [W-1:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic         i_done, i_stall, d_done, d_stall, mem_req, mem_we, busy;
    state_t       state_dbg;
    logic [2:0]   starve_dbg;
`ifdef ARB_PERF_CNT_EN
    logic [15:0]  perf_i_wait, perf_d_wait, perf_grants;
    int           m_pi, m_pd, m_pg;
`endif

    unified_mem_arbiter #(.WORD_SIZE(W), .STARVE_MAX(STARVE_MAX), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .d_done(d_done), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy),
`ifdef ARB_PERF_CNT_EN
        .perf_i_wait(perf_i_wait), .perf_d_wait(perf_d_wait), .perf_grants(perf_grants),
`endif
        .state_dbg(state_dbg), .starve_dbg(starve_dbg)
    );

    // ---------------- scoreboard / model state ----------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc;
    logic [W-1:0] mem_img [logic [W-1:0]];
    logic [W-1:0] exp_q [$];           // expected read data, in grant order
    bit           obs_q [$];           // observed completions: 1 = D, 0 = I
    int  m_idle_at, m_busy_lo, m_busy_hi, m_done_cyc, m_starve;
    bit  m_own_d, m_we;
    logic [W-1:0] m_addr, m_wdata, exp_i_rdata, exp_d_rdata;
    int  fixed_delay;
    int  d_auto;
    int  memreq_cycles;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] img_read(input logic [W-1:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return a ^ 16'hC3A5;
    endfunction

    task automatic model_reset();
        m_idle_at = cyc; m_busy_lo = -10; m_busy_hi = -11; m_done_cyc = -10;
        m_starve = 0; m_own_d = 0; m_we = 0; m_addr = '0; m_wdata = '0;
        exp_i_rdata = '0; exp_d_rdata = '0; exp_q.delete(); d_auto = 0;
`ifdef ARB_PERF_CNT_EN
        m_pi = 0; m_pd = 0; m_pg = 0;
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue_i(input logic [W-1:0] a);
        i_req = 1'b1; i_addr = a;
    endtask

    task automatic issue_d(input bit we, input logic [W-1:0] a, input logic [W-1:0] wd);
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    endtask

    // Grant decision from the arbitration rules; access timing by plain arithmetic.
    task automatic decide();
        bit gd;
        int k;
        if (cyc >= m_idle_at && (i_req || d_req)) begin
            gd = d_req && !(i_req && m_starve == STARVE_MAX);
            if (gd && i_req) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : m_starve;
            else             m_starve = 0;
            k = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
            m_own_d = gd;
            if (gd) begin
                m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
                if (d_we) mem_img[d_addr] = d_wdata;
                else      exp_q.push_back(img_read(d_addr));
            end else begin
                m_we = 1'b0; m_addr = i_addr; m_wdata = '0;
                exp_q.push_back(img_read(i_addr));
            end
            m_busy_lo  = cyc + 1;
            m_busy_hi  = cyc + 1 + k;
            m_done_cyc = cyc + 2 + k;
            m_idle_at  = cyc + 3 + k;
`ifdef ARB_PERF_CNT_EN
            m_pg++;
`endif
        end
    endtask

    // Memory model: acks at the planned cycle, random noise on ack/rdata outside the access.
    task automatic respond_mem();
        if (cyc >= m_busy_lo && cyc <= m_busy_hi) begin
            mem_ack   = (cyc == m_busy_hi);
            mem_rdata = mem_ack ? img_read(mem_addr) : W'($urandom);
        end else begin
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = W'($urandom);
        end
    endtask

    task automatic check_outputs();
        bit     e_busy, e_resp;
        state_t e_state;
        e_busy  = (cyc >= m_busy_lo && cyc <= m_busy_hi);
        e_resp  = (cyc == m_done_cyc);
        e_state = e_busy ? BUSY : (e_resp ? RESP : IDLE);
        if (e_resp && (!m_own_d || !m_we)) begin
            if (!m_own_d) exp_i_rdata = exp_q.pop_front();
            else          exp_d_rdata = exp_q.pop_front();
        end
        chk("mem_req",  mem_req,   e_busy);
        chk("busy",     busy,      e_busy || e_resp);
        chk("state",    state_dbg, e_state);
        chk("i_done",   i_done,    e_resp && !m_own_d);
        chk("d_done",   d_done,    e_resp && m_own_d);
        chk("i_stall",  i_stall,   i_req && !(e_resp && !m_own_d));
        chk("d_stall",  d_stall,   d_req && !(e_resp && m_own_d));
        chk("i_rdata",  i_rdata,   exp_i_rdata);
        chk("d_rdata",  d_rdata,   exp_d_rdata);
        chk("starve",   starve_dbg, m_starve);
        chk("mem_we",   mem_we,    m_we);
        chk("mem_addr", mem_addr,  m_addr);
        if (e_busy && m_we) chk("mem_wdata", mem_wdata, m_wdata);
        if (mem_req) memreq_cycles++;
        if (i_done) obs_q.push_back(1'b0);
        if (d_done) obs_q.push_back(1'b1);
    endtask

    task automatic retire();
        if (cyc == m_done_cyc) begin
            if (!m_own_d) begin
                i_req = 1'b0;
            end else if (d_auto > 0) begin
                d_auto--;
                issue_d(1'b0, d_addr + 16'h0001, '0);
            end else begin
                d_req = 1'b0;
            end
        end
    endtask

    task automatic step();
        decide();
`ifdef ARB_PERF_CNT_EN
        if (i_req && !(cyc == m_done_cyc && !m_own_d)) m_pi++;
        if (d_req && !(cyc == m_done_cyc && m_own_d))  m_pd++;
`endif
        respond_mem();
        @(negedge clk);
        cyc++;
        check_outputs();
        retire();
    endtask

    task automatic run_until_idle(input int max_cycles);
        int n;
        n = 0;
        while (!(cyc >= m_idle_at && !i_req && !d_req) && n < max_cycles) begin
            step();
            n++;
        end
        chk("drain_timeout", n < max_cycles, 1'b1);
    endtask

    task automatic reset_checks();
        chk("rst_mem_req", mem_req,   1'b0);
        chk("rst_busy",    busy,      1'b0);
        chk("rst_i_done",  i_done,    1'b0);
        chk("rst_d_done",  d_done,    1'b0);
        chk("rst_state",   state_dbg, IDLE);
        chk("rst_i_rdata", i_rdata,   16'h0000);
        chk("rst_d_rdata", d_rdata,   16'h0000);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_starve",  starve_dbg, 3'd0);
`ifdef ARB_PERF_CNT_EN
        chk("rst_perf_grants", perf_grants, 16'd0);
        chk("rst_perf_i_wait", perf_i_wait, 16'd0);
`endif
    endtask

    task automatic do_reset_mid();
        #2 reset = 1'b1;
        #1 reset_checks();
        i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        cyc++;
        reset = 1'b0;
        model_reset();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int n_done_before;
        reset = 1'b1;
        i_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        cyc = 0; fixed_delay = 0; memreq_cycles = 0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_checks();
        reset = 1'b0;
        model_reset();

        // 1: single fetch, ack on first BUSY cycle
        mem_img[16'h0010] = 16'h6A01;
        issue_i(16'h0010);
        run_until_idle(20);
        chk("t1_i_rdata", i_rdata, 16'h6A01);

        // 2: simultaneous requests, D write wins, then I
        obs_q.delete();
        issue_d(1'b1, 16'h0080, 16'h1234);
        issue_i(16'h0020);
        run_until_idle(30);
        chk("t2_n_done", obs_q.size(), 2);
        chk("t2_first_is_d", obs_q[0], 1'b1);
        chk("t2_d_rdata_kept", d_rdata, 16'h0000);
`ifdef ARB_PERF_CNT_EN
        chk("t6_perf_grants", perf_grants, 16'd3);
        chk("t6_perf_i_wait", perf_i_wait, 16'(m_pi));
        chk("t6_perf_d_wait", perf_d_wait, 16'(m_pd));
`endif

        // 3: D held over 5 accesses with fetch pending -> D,D,D,D,I
        obs_q.delete();
        issue_i(16'h0100);
        issue_d(1'b0, 16'h0180, '0);
        d_auto = 4;
        run_until_idle(80);
        chk("t3_n_done", obs_q.size(), 6);
        for (int g = 0; g < 5; g++) chk($sformatf("t3_grant%0d", g), obs_q[g], (g < 4) ? 1'b1 : 1'b0);
        chk("t3_starve_end", starve_dbg, 3'd0);

        // 4: delayed ack on a D read
        fixed_delay = 3;
        memreq_cycles = 0;
        mem_img[16'h0200] = 16'hBEEF;
        issue_d(1'b0, 16'h0200, '0);
        run_until_idle(30);
        chk("t4_memreq_cycles", memreq_cycles, 4);
        chk("t4_d_rdata", d_rdata, 16'hBEEF);

        // 5: reset mid-BUSY, then a fresh fetch
        fixed_delay = 5;
        mem_img[16'h0040] = 16'h1357;
        issue_i(16'h0040);
        repeat (3) step();
        do_reset_mid();
        fixed_delay = 0;
        obs_q.delete();
        issue_i(16'h0040);
        run_until_idle(20);
        chk("t5_n_done", obs_q.size(), 1);
        chk("t5_i_rdata", i_rdata, 16'h1357);

        // random traffic
        fixed_delay = -1;
        for (int t = 0; t < 600; t++) begin
            if (!i_req && $urandom_range(0, 2) == 0)
                issue_i(W'($urandom) & 16'hF00F);
            if (!d_req && $urandom_range(0, 2) == 0)
                issue_d(1'($urandom_range(0, 1)), W'($urandom) & 16'hF00F, W'($urandom));
            step();
        end
        run_until_idle(40);
        n_done_before = exp_q.size();
        chk("rand_exp_q_empty", n_done_before, 0);
`ifdef ARB_PERF_CNT_EN
        chk("rand_perf_grants", perf_grants, 16'(m_pg));
        chk("rand_perf_i_wait", perf_i_wait, 16'(m_pi));
        chk("rand_perf_d_wait", perf_d_wait, 16'(m_pd));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
